// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift/compare ops plus
// iterative shift-add multiply and restoring divide, one operation in flight.
module alu_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [3:0]            ALUctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUout,
    output logic                  EQ,
    output logic                  LT,
    output logic                  LTU
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam logic [SHW-1:0] LAST_ITER = SHW'(DATA_WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_op;
    logic [SHW-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_out_valid;
    logic                  r_eq;
    logic                  r_lt;
    logic                  r_ltu;

    logic                  w_accept;
    logic                  w_is_iter;
    logic                  w_op_valid;
    logic                  w_last;
    logic                  w_eq;
    logic                  w_lt;
    logic                  w_ltu;
    logic [SHW-1:0]        w_shamt;
    logic [DATA_WIDTH-1:0] w_single;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [DATA_WIDTH-1:0] w_q_next;
    logic [DATA_WIDTH-1:0] w_iter_result;

    assign w_accept   = in_valid && in_ready;
    assign w_is_iter  = (ALUctrl == OP_MUL) || (ALUctrl == OP_DIVU) || (ALUctrl == OP_REMU);
    assign w_op_valid = (ALUctrl <= OP_REMU);
    assign w_last     = (r_cnt == LAST_ITER);

    assign w_eq    = (in0 == in1);
    assign w_lt    = ($signed(in0) < $signed(in1));
    assign w_ltu   = (in0 < in1);
    assign w_shamt = in1[SHW-1:0];

    always_comb begin
        w_single = '0;
        case (ALUctrl)
            OP_ADD:  w_single = in0 + in1;
            OP_SUB:  w_single = in0 - in1;
            OP_AND:  w_single = in0 & in1;
            OP_OR:   w_single = in0 | in1;
            OP_XOR:  w_single = in0 ^ in1;
            OP_SLL:  w_single = in0 << w_shamt;
            OP_SRL:  w_single = in0 >> w_shamt;
            OP_SRA:  w_single = $unsigned($signed(in0) >>> w_shamt);
            OP_SLT:  w_single = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            OP_SLTU: w_single = {{(DATA_WIDTH-1){1'b0}}, w_ltu};
            default: w_single = '0;
        endcase
    end

    // Multiply: r_a is the shifting multiplicand, r_b the shifting multiplier.
    assign w_acc_next = r_b[0] ? (r_acc + r_a) : r_acc;

    // Divide: r_a shifts the dividend out MSB-first and collects quotient bits.
    // A zero divisor always "fits", giving all-ones quotient and rem = dividend.
    assign w_shift    = {r_rem, r_a[DATA_WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_ge       = !w_diff[DATA_WIDTH];
    assign w_rem_next = w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    assign w_q_next   = {r_a[DATA_WIDTH-2:0], w_ge};

    always_comb begin
        w_iter_result = w_rem_next;
        if (r_op == OP_MUL) begin
            w_iter_result = w_acc_next;
        end else if (r_op == OP_DIVU) begin
            w_iter_result = w_q_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_is_iter ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_IDLE) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_ltu       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= ALUctrl;
                        r_cnt <= '0;
                        r_a   <= in0;
                        r_b   <= in1;
                        r_acc <= '0;
                        r_rem <= '0;
                        r_eq  <= w_op_valid && w_eq;
                        r_lt  <= w_op_valid && w_lt;
                        r_ltu <= w_op_valid && w_ltu;
                        if (!w_is_iter) begin
                            r_result    <= w_single;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op == OP_MUL) begin
                        r_acc <= w_acc_next;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end else begin
                        r_rem <= w_rem_next;
                        r_a   <= w_q_next;
                    end
                    if (w_last) begin
                        r_result    <= w_iter_result;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign ALUout    = r_result;
    assign EQ        = r_eq;
    assign LT        = r_lt;
    assign LTU       = r_ltu;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an arithmetic reference model checked every valid
// cycle, plus hand-computed literal results, latency, handshake and reset checks.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic [3:0]   ALUctrl = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] ALUout;
    logic         EQ;
    logic         LT;
    logic         LTU;

    int ntests = 0;
    int nfail  = 0;

    logic         exp_armed = 1'b0;
    logic [W-1:0] exp_res = '0;
    logic         exp_eq = 1'b0;
    logic         exp_lt = 1'b0;
    logic         exp_ltu = 1'b0;

    logic [W-1:0] got_res;
    logic         got_eq;
    logic         got_lt;
    logic         got_ltu;

    always #5 clk = ~clk;

    alu_seq #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .ALUctrl   (ALUctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUout    (ALUout),
        .EQ        (EQ),
        .LT        (LT),
        .LTU       (LTU)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference: {EQ, LT, LTU, ALUout} straight from the opcode definitions.
    function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         f_eq, f_lt, f_ltu;
        int           sh;
        sh = int'(b % W);
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << sh;
            4'd6:    r = a >> sh;
            4'd7:    r = $unsigned($signed(a) >>> sh);
            4'd8:    r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'd9:    r = (a < b) ? W'(1) : W'(0);
            4'd10:   r = a * b;
            4'd11:   r = (b == 0) ? '1 : a / b;
            4'd12:   r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        f_eq  = (op <= 4'd12) && (a == b);
        f_lt  = (op <= 4'd12) && ($signed(a) < $signed(b));
        f_ltu = (op <= 4'd12) && (a < b);
        return {f_eq, f_lt, f_ltu, r};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!exp_armed) begin
                ntests++;
                nfail++;
                $display("FAIL spurious_valid: got out_valid=1 ALUout=%h, required no result", ALUout);
            end else begin
                chk("mon_ALUout", ALUout, exp_res);
                chk("mon_EQ", W'(EQ), W'(exp_eq));
                chk("mon_LT", W'(LT), W'(exp_lt));
                chk("mon_LTU", W'(LTU), W'(exp_ltu));
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input bit early);
        logic [W+2:0] m;
        int           n;
        bit           busy_bad;
        bit           iter;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_wait", W'(in_ready), W'(1));
            return;
        end
        iter = (op == 4'd10) || (op == 4'd11) || (op == 4'd12);
        in_valid  = 1'b1;
        ALUctrl   = op;
        in0       = a;
        in1       = b;
        out_ready = early;
        @(posedge clk);
        m = model(op, a, b);
        exp_res   = m[W-1:0];
        exp_ltu   = m[W];
        exp_lt    = m[W+1];
        exp_eq    = m[W+2];
        exp_armed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in0      = $urandom;
        in1      = $urandom;
        ALUctrl  = 4'($urandom_range(0, 15));
        n = 0;
        busy_bad = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) busy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("latency", W'(n), iter ? W'(W) : W'(0));
        chk("busy_in_ready", W'(busy_bad), W'(0));
        got_res = ALUout;
        got_eq  = EQ;
        got_lt  = LT;
        got_ltu = LTU;
        if (early) begin
            @(negedge clk);
            chk("one_cycle_valid", W'(out_valid), W'(0));
            chk("handoff_in_ready", W'(in_ready), W'(1));
            out_ready = 1'b0;
        end else begin
            for (int s = 0; s < stall; s++) begin
                in_valid = 1'b1;
                in0      = $urandom;
                in1      = $urandom;
                @(negedge clk);
                chk("stall_in_ready", W'(in_ready), W'(0));
                chk("stall_hold", ALUout, got_res);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            chk("consumed", W'(out_valid), W'(0));
            chk("handoff_in_ready", W'(in_ready), W'(1));
            out_ready = 1'b0;
        end
        exp_armed = 1'b0;
        $display("[TB] op=%0d a=%h b=%h -> ALUout=%h EQ=%0d LT=%0d LTU=%0d lat=%0d",
                 op, a, b, got_res, got_eq, got_lt, got_ltu, n);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_ALUout", ALUout, W'(0));
        chk("rst_flags", W'({EQ, LT, LTU}), W'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", W'(in_ready), W'(1));

        run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 0, 1'b0);
        chk("add_lit", got_res, 32'h8000_0000);
        chk("add_flags", W'({got_eq, got_lt, got_ltu}), W'(3'b000));
        run_op(4'd1, 32'd5, 32'd5, 0, 1'b0);
        chk("sub_lit", got_res, 32'h0);
        chk("sub_eq", W'(got_eq), W'(1));
        run_op(4'd7, 32'h8000_0000, 32'h24, 0, 1'b0);
        chk("sra_lit", got_res, 32'hF800_0000);
        run_op(4'd5, 32'h1, 32'd31, 0, 1'b0);
        chk("sll_lit", got_res, 32'h8000_0000);
        run_op(4'd6, 32'hF000_0000, 32'd4, 0, 1'b0);
        chk("srl_lit", got_res, 32'h0F00_0000);
        run_op(4'd8, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
        chk("slt_lit", got_res, 32'h1);
        chk("slt_flags", W'({got_lt, got_ltu}), W'(2'b10));
        run_op(4'd9, 32'h1, 32'hFFFF_FFFF, 0, 1'b0);
        chk("sltu_lit", got_res, 32'h1);
        run_op(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
        run_op(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
        run_op(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
        run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        chk("mul_lit", got_res, 32'h1);
        run_op(4'd10, 32'd12345, 32'd678, 0, 1'b1);
        chk("mul2_lit", got_res, 32'd8369910);
        run_op(4'd11, 32'd100, 32'd7, 0, 1'b0);
        chk("divu_lit", got_res, 32'd14);
        run_op(4'd12, 32'd100, 32'd7, 0, 1'b0);
        chk("remu_lit", got_res, 32'd2);
        run_op(4'd11, 32'd9, 32'd0, 0, 1'b0);
        chk("divu0_lit", got_res, 32'hFFFF_FFFF);
        run_op(4'd12, 32'd9, 32'd0, 0, 1'b0);
        chk("remu0_lit", got_res, 32'd9);
        run_op(4'd11, 32'hFFFF_FFFF, 32'd3, 0, 1'b0);
        chk("divu_big_lit", got_res, 32'h5555_5555);
        run_op(4'd0, 32'd12, 32'd30, 5, 1'b0);
        chk("stall_add_lit", got_res, 32'd42);
        run_op(4'd14, 32'd3, 32'd3, 0, 1'b0);
        chk("inv_lit", got_res, 32'h0);
        chk("inv_flags", W'({got_eq, got_lt, got_ltu}), W'(3'b000));
        run_op(4'd0, 32'h1234_5678, 32'h0, 0, 1'b0);

        // Reset during the tenth BUSY cycle of a multiply.
        in_valid = 1'b1;
        ALUctrl  = 4'd10;
        in0      = 32'd3;
        in1      = 32'd5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_ALUout", ALUout, W'(0));
        chk("midrst_flags", W'({EQ, LT, LTU}), W'(0));
        chk("midrst_in_ready", W'(in_ready), W'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_after", W'(in_ready), W'(1));
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_result", W'(seen), W'(0));
        $display("[TB] reset during MUL: out_valid seen afterwards=%0d", seen);

        run_op(4'd0, 32'd1, 32'd2, 0, 1'b0);
        chk("recover_lit", got_res, 32'd3);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
